// File: rtl/smm_operand_loader.sv
// Operand loader for the SMM1 Strassen core: packs a streamed A-then-B element
// sequence into flat operand buses, strobes load, then freezes the operands.
module smm_operand_loader #(
    parameter  int DATAWIDTH   = 32,
    parameter  int BLOCKSIZE   = 2,
    parameter  int HOLD_CYCLES = 8,
    localparam int BUSWIDTH    = DATAWIDTH * BLOCKSIZE * BLOCKSIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    input  logic                 cfg_sel,
    output logic [BUSWIDTH-1:0]  A,
    output logic [BUSWIDTH-1:0]  B,
    output logic                 load,
    output logic                 sel,
    output logic                 busy,
    output logic                 err,
    output logic [7:0]           frame_cnt
);

    localparam int N     = BLOCKSIZE * BLOCKSIZE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_FILL_A = 2'd0;
    localparam logic [1:0] ST_FILL_B = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       nxt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] hcnt;
    logic             beat;

    assign beat = s_valid && s_ready;
    assign load = (state == ST_LOAD);
    assign busy = (state == ST_LOAD) || (state == ST_HOLD);

    always_comb begin
        nxt = state;
        case (state)
            ST_FILL_A: begin
                if (beat && !s_last && idx == LAST_IDX) nxt = ST_FILL_B;
            end
            ST_FILL_B: begin
                if (beat) begin
                    if (idx == LAST_IDX && s_last)       nxt = ST_LOAD;
                    else if (idx == LAST_IDX || s_last) nxt = ST_FILL_A;
                end
            end
            ST_LOAD: nxt = ST_HOLD;
            ST_HOLD: begin
                if (hcnt == '0) nxt = ST_FILL_A;
            end
            default: nxt = ST_FILL_A;
        endcase
    end

    // s_ready is registered from the next state so it drops in the LOAD cycle itself
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL_A;
            idx       <= '0;
            hcnt      <= '0;
            A         <= '0;
            B         <= '0;
            sel       <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= 8'd0;
            s_ready   <= 1'b0;
        end else begin
            state   <= nxt;
            s_ready <= (nxt == ST_FILL_A) || (nxt == ST_FILL_B);
            case (state)
                ST_FILL_A: begin
                    if (beat) begin
                        A[idx*DATAWIDTH +: DATAWIDTH] <= s_data;
                        if (idx == '0) sel <= cfg_sel;
                        if (s_last) begin
                            err <= 1'b1;
                            idx <= '0;
                        end else if (idx == LAST_IDX) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_FILL_B: begin
                    if (beat) begin
                        B[idx*DATAWIDTH +: DATAWIDTH] <= s_data;
                        if (idx == LAST_IDX || s_last) begin
                            idx <= '0;
                            // anything but s_last exactly on the final element is a framing error
                            if (idx != LAST_IDX || !s_last) err <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    hcnt      <= HOLD_INIT;
                end
                ST_HOLD: begin
                    if (hcnt != '0) hcnt <= hcnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
